// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a register scoreboard.
// Loads have absolute priority on the single write port. ALU results wait in
// a 2-entry FIFO, or skip it when the port is free and the FIFO is empty.
// A 32-bit pending scoreboard stalls decode on RAW/WAW hazards. A sticky
// error flag records any write to a register that had no outstanding claim.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_src1,
  input  logic [4:0]  issue_src2,
  input  logic [4:0]  issue_dest,
  output logic        issue_stall,
  output logic        rf_write_enable,
  output logic [4:0]  rf_dest,
  output logic        rf_mem_sel,
  output logic [31:0] rf_alu_data,
  output logic [31:0] rf_mem_data,
  output logic [31:0] pending,
  output logic        wb_error
);

  // ALU request FIFO: two slots, wrapping 1-bit pointers, explicit occupancy
  logic [4:0]  fifo_dest_reg [2];
  logic [31:0] fifo_data_reg [2];
  logic        rd_ptr_reg, rd_ptr_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic [1:0]  count_reg, count_next;

  // Registered write-port state
  logic        rf_we_reg, rf_we_next;
  logic [4:0]  rf_dest_reg, rf_dest_next;
  logic        rf_sel_reg, rf_sel_next;
  logic [31:0] rf_alu_data_reg, rf_alu_data_next;
  logic [31:0] rf_mem_data_reg, rf_mem_data_next;

  // Scoreboard and error flag
  logic [31:0] pending_reg, pending_next;
  logic [31:0] set_vec, clr_vec;
  logic        wb_error_reg, wb_error_next;

  logic        alu_accept;
  logic        push, pop;

  assign alu_ready  = !rst && (count_reg < 2'd2);
  assign alu_accept = alu_valid && alu_ready;

  // Hazard check is purely combinational so decode can hold the same cycle
  assign issue_stall = issue_valid &&
                       (pending_reg[issue_src1] || pending_reg[issue_src2] ||
                        pending_reg[issue_dest]);

  // Pick this cycle's write: load first, then FIFO head, then direct ALU bypass
  always_comb begin
    rf_we_next       = 1'b0;
    rf_dest_next     = rf_dest_reg;
    rf_sel_next      = rf_sel_reg;
    rf_alu_data_next = rf_alu_data_reg;
    rf_mem_data_next = rf_mem_data_reg;
    push             = 1'b0;
    pop              = 1'b0;
    if (mem_valid) begin
      rf_we_next       = 1'b1;
      rf_dest_next     = mem_dest;
      rf_sel_next      = 1'b1;
      rf_mem_data_next = mem_data;
      push             = alu_accept;
    end else if (count_reg != 2'd0) begin
      rf_we_next       = 1'b1;
      rf_dest_next     = fifo_dest_reg[rd_ptr_reg];
      rf_sel_next      = 1'b0;
      rf_alu_data_next = fifo_data_reg[rd_ptr_reg];
      pop              = 1'b1;
      push             = alu_accept;
    end else if (alu_accept) begin
      rf_we_next       = 1'b1;
      rf_dest_next     = alu_dest;
      rf_sel_next      = 1'b0;
      rf_alu_data_next = alu_data;
    end
  end

  // FIFO pointer / occupancy bookkeeping; push and pop together leave count alone
  always_comb begin
    wr_ptr_next = push ? ~wr_ptr_reg : wr_ptr_reg;
    rd_ptr_next = pop  ? ~rd_ptr_reg : rd_ptr_reg;
    count_next  = count_reg + {1'b0, push} - {1'b0, pop};
  end

  // Scoreboard set/clear vectors; a clear lands one edge after the write strobe
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && !issue_stall) set_vec = 32'd1 << issue_dest;
    if (rf_we_reg)                   clr_vec = 32'd1 << rf_dest_reg;
  end

  // Per-bit scoreboard update: a coincident set beats a clear
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pend
      assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
    end
  endgenerate

  // Error latches when a write is scheduled for a register nobody claimed
  assign wb_error_next = wb_error_reg | (rf_we_next && !pending_reg[rf_dest_next]);

  // FIFO storage: data slots need no reset, occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_dest_reg[wr_ptr_reg] <= alu_dest;
      fifo_data_reg[wr_ptr_reg] <= alu_data;
    end
  end

  // Control, write-port and scoreboard state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg      <= 1'b0;
      wr_ptr_reg      <= 1'b0;
      count_reg       <= 2'd0;
      rf_we_reg       <= 1'b0;
      rf_dest_reg     <= 5'd0;
      rf_sel_reg      <= 1'b0;
      rf_alu_data_reg <= 32'd0;
      rf_mem_data_reg <= 32'd0;
      pending_reg     <= 32'd0;
      wb_error_reg    <= 1'b0;
    end else begin
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      count_reg       <= count_next;
      rf_we_reg       <= rf_we_next;
      rf_dest_reg     <= rf_dest_next;
      rf_sel_reg      <= rf_sel_next;
      rf_alu_data_reg <= rf_alu_data_next;
      rf_mem_data_reg <= rf_mem_data_next;
      pending_reg     <= pending_next;
      wb_error_reg    <= wb_error_next;
    end
  end

  assign rf_write_enable = rf_we_reg;
  assign rf_dest         = rf_dest_reg;
  assign rf_mem_sel      = rf_sel_reg;
  assign rf_alu_data     = rf_alu_data_reg;
  assign rf_mem_data     = rf_mem_data_reg;
  assign pending         = pending_reg;
  assign wb_error        = wb_error_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter.
// Each record holds one cycle of inputs and the hand-computed outputs:
// alu_ready / issue_stall before the edge, registered outputs after it.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_dest = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_dest = '0;
  logic [31:0] mem_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_src1 = '0;
  logic [4:0]  issue_src2 = '0;
  logic [4:0]  issue_dest = '0;
  logic        issue_stall;
  logic        rf_write_enable;
  logic [4:0]  rf_dest;
  logic        rf_mem_sel;
  logic [31:0] rf_alu_data;
  logic [31:0] rf_mem_data;
  logic [31:0] pending;
  logic        wb_error;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_dest(issue_dest), .issue_stall(issue_stall),
    .rf_write_enable(rf_write_enable), .rf_dest(rf_dest), .rf_mem_sel(rf_mem_sel),
    .rf_alu_data(rf_alu_data), .rf_mem_data(rf_mem_data),
    .pending(pending), .wb_error(wb_error)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mdata;
    logic        iv;
    logic [4:0]  s1, s2, id;
    logic        e_ready, e_stall, e_we;
    logic [4:0]  e_dest;
    logic        e_sel;
    logic [31:0] e_alu, e_mem, e_pend;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_chk  = 0;

  function automatic vec_t mk(input int r, av, ad, input logic [31:0] adata,
                              input int mv, md, input logic [31:0] mdata,
                              input int iv, s1, s2, id,
                              input int er, es, ewe, edest, esel,
                              input logic [31:0] ealu, emem, epend, input int eerr);
    vec_t v;
    v.rst = 1'(r);   v.av = 1'(av);   v.ad = 5'(ad);   v.adata = adata;
    v.mv = 1'(mv);   v.md = 5'(md);   v.mdata = mdata;
    v.iv = 1'(iv);   v.s1 = 5'(s1);   v.s2 = 5'(s2);   v.id = 5'(id);
    v.e_ready = 1'(er); v.e_stall = 1'(es); v.e_we = 1'(ewe);
    v.e_dest = 5'(edest); v.e_sel = 1'(esel);
    v.e_alu = ealu; v.e_mem = emem; v.e_pend = epend; v.e_err = 1'(eerr);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", n_vec, nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    alu_valid = v.av;   alu_dest = v.ad;  alu_data = v.adata;
    mem_valid = v.mv;   mem_dest = v.md;  mem_data = v.mdata;
    issue_valid = v.iv; issue_src1 = v.s1; issue_src2 = v.s2; issue_dest = v.id;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk("alu_ready", 32'(alu_ready), 32'(v.e_ready));
    chk("issue_stall", 32'(issue_stall), 32'(v.e_stall));
    @(posedge clk);
    #1;
    chk("rf_write_enable", 32'(rf_write_enable), 32'(v.e_we));
    if (v.e_we) begin
      chk("rf_dest", 32'(rf_dest), 32'(v.e_dest));
      chk("rf_mem_sel", 32'(rf_mem_sel), 32'(v.e_sel));
    end
    chk("rf_alu_data", rf_alu_data, v.e_alu);
    chk("rf_mem_data", rf_mem_data, v.e_mem);
    chk("pending", pending, v.e_pend);
    chk("wb_error", 32'(wb_error), 32'(v.e_err));
    $display("vec %0d: we=%0b dest=%0d sel=%0b alu=%h mem=%h pend=%h err=%0b",
             n_vec, rf_write_enable, rf_dest, rf_mem_sel, rf_alu_data, rf_mem_data,
             pending, wb_error);
    n_vec++;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    //            rst av ad adata        mv md mdata        iv s1 s2 id  rdy stl we dst sel alu          mem          pend          err
    // reset
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  0, 0, 0, 0, 0, 0,           0,           0,            0));
    // issue r3, then ALU bypass write of r3, then pending clears
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 1, 2, 3,  1, 0, 0, 0, 0, 0,           0,           32'h8,        0));
    tbl.push_back(mk(0, 1, 3, DB,          0, 0, 0,           0, 0, 0, 0,  1, 0, 1, 3, 0, DB,          0,           32'h8,        0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 0, 0, 0, DB,          0,           0,            0));
    // claim r7, r20; simultaneous mem r7 + ALU r20
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 7,  1, 0, 0, 0, 0, DB,          0,           32'h80,       0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 20, 1, 0, 0, 0, 0, DB,          0,           32'h00100080, 0));
    tbl.push_back(mk(0, 1, 20, 32'h22220014, 1, 7, 32'h11110007, 0, 0, 0, 0, 1, 0, 1, 7, 1, DB,        32'h11110007, 32'h00100080, 0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 1, 20, 0, 32'h22220014, 32'h11110007, 32'h00100000, 0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h22220014, 32'h11110007, 0,          0));
    // claim r8..r13
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 8,  1, 0, 0, 0, 0, 32'h22220014, 32'h11110007, 32'h100,    0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 9,  1, 0, 0, 0, 0, 32'h22220014, 32'h11110007, 32'h300,    0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 10, 1, 0, 0, 0, 0, 32'h22220014, 32'h11110007, 32'h700,    0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 11, 1, 0, 0, 0, 0, 32'h22220014, 32'h11110007, 32'hF00,    0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 12, 1, 0, 0, 0, 0, 32'h22220014, 32'h11110007, 32'h1F00,   0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 13, 1, 0, 0, 0, 0, 32'h22220014, 32'h11110007, 32'h3F00,   0));
    // mem held 3 cycles, ALU every cycle: FIFO fills, ready drops, drains in order
    tbl.push_back(mk(0, 1, 11, 32'hBBBB000B, 1, 8, 32'hAAAA0008, 0, 0, 0, 0, 1, 0, 1, 8, 1, 32'h22220014, 32'hAAAA0008, 32'h3F00, 0));
    tbl.push_back(mk(0, 1, 12, 32'hBBBB000C, 1, 9, 32'hAAAA0009, 0, 0, 0, 0, 1, 0, 1, 9, 1, 32'h22220014, 32'hAAAA0009, 32'h3E00, 0));
    tbl.push_back(mk(0, 1, 13, 32'hBBBB000D, 1, 10, 32'hAAAA000A, 0, 0, 0, 0, 0, 0, 1, 10, 1, 32'h22220014, 32'hAAAA000A, 32'h3C00, 0));
    tbl.push_back(mk(0, 1, 13, 32'hBBBB000D, 0, 0, 0,         0, 0, 0, 0,  0, 0, 1, 11, 0, 32'hBBBB000B, 32'hAAAA000A, 32'h3800, 0));
    tbl.push_back(mk(0, 1, 13, 32'hBBBB000D, 0, 0, 0,         0, 0, 0, 0,  1, 0, 1, 12, 0, 32'hBBBB000C, 32'hAAAA000A, 32'h3000, 0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 1, 13, 0, 32'hBBBB000D, 32'hAAAA000A, 32'h2000, 0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 0, 0, 0, 32'hBBBB000D, 32'hAAAA000A, 0,        0));
    // RAW/WAW stall on r3 until the edge after its write
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 3,  1, 0, 0, 0, 0, 32'hBBBB000D, 32'hAAAA000A, 32'h8,    0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 3, 0, 4,  1, 1, 0, 0, 0, 32'hBBBB000D, 32'hAAAA000A, 32'h8,    0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 0, 0, 3,  1, 1, 0, 0, 0, 32'hBBBB000D, 32'hAAAA000A, 32'h8,    0));
    tbl.push_back(mk(0, 1, 3, 32'h33333333, 0, 0, 0,          1, 3, 0, 4,  1, 1, 1, 3, 0, 32'h33333333, 32'hAAAA000A, 32'h8,    0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 3, 0, 4,  1, 1, 0, 0, 0, 32'h33333333, 32'hAAAA000A, 0,        0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           1, 3, 0, 4,  1, 0, 0, 0, 0, 32'h33333333, 32'hAAAA000A, 32'h10,   0));
    tbl.push_back(mk(0, 1, 4, 32'h44444444, 0, 0, 0,          0, 0, 0, 0,  1, 0, 1, 4, 0, 32'h44444444, 32'hAAAA000A, 32'h10,   0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h44444444, 32'hAAAA000A, 0,        0));
    // unclaimed write to r5: performed, error sticks
    tbl.push_back(mk(0, 1, 5, 32'h55555555, 0, 0, 0,          0, 0, 0, 0,  1, 0, 1, 5, 0, 32'h55555555, 32'hAAAA000A, 0,        1));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h55555555, 32'hAAAA000A, 0,        1));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h55555555, 32'hAAAA000A, 0,        1));
    // fill FIFO behind mem traffic, then reset mid-operation
    tbl.push_back(mk(0, 1, 14, 32'hDDDD000E, 1, 16, 32'hCCCC0010, 0, 0, 0, 0, 1, 0, 1, 16, 1, 32'h55555555, 32'hCCCC0010, 0,    1));
    tbl.push_back(mk(0, 1, 15, 32'hDDDD000F, 1, 16, 32'hCCCC0011, 0, 0, 0, 0, 1, 0, 1, 16, 1, 32'h55555555, 32'hCCCC0011, 0,    1));
    tbl.push_back(mk(1, 1, 17, 32'h12345678, 1, 18, 32'h87654321, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0,          0,           0,        0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 0, 0, 0, 0,           0,           0,        0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0, 0, 0,  1, 0, 0, 0, 0, 0,           0,           0,        0));

    foreach (tbl[i]) apply(tbl[i]);

    // Hand sequence: ALU write to r6 queued behind two loads, found within a bounded wait
    begin
      logic found;
      vec_t idle;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      foreach (idle.e_pend[k]) idle.e_pend[k] = 1'b0;
      @(negedge clk); drive(idle); issue_valid = 1'b1; issue_dest = 5'd21;
      @(negedge clk); issue_dest = 5'd22;
      @(negedge clk); issue_dest = 5'd6;
      @(posedge clk); #1;
      chk("pending_claims", pending, 32'h00600040);
      n_vec++;
      @(negedge clk);
      issue_valid = 1'b0;
      mem_valid = 1'b1; mem_dest = 5'd21; mem_data = 32'h77770015;
      alu_valid = 1'b1; alu_dest = 5'd6;  alu_data = 32'h66666666;
      @(posedge clk); #1;
      chk("load21_dest", 32'(rf_dest), 32'd21);
      chk("load21_sel", 32'(rf_mem_sel), 32'd1);
      n_vec++;
      @(negedge clk);
      alu_valid = 1'b0;
      mem_dest = 5'd22; mem_data = 32'h77770016;
      @(posedge clk); #1;
      chk("load22_dest", 32'(rf_dest), 32'd22);
      chk("load22_data", rf_mem_data, 32'h77770016);
      n_vec++;
      @(negedge clk);
      mem_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        @(posedge clk); #1;
        if (rf_write_enable && !rf_mem_sel) found = 1'b1;
      end
      chk("alu6_seen", 32'(found), 32'd1);
      chk("alu6_dest", 32'(rf_dest), 32'd6);
      chk("alu6_data", rf_alu_data, 32'h66666666);
      n_vec++;
      @(posedge clk); #1;
      chk("pending_drained", pending, 32'd0);
      chk("no_error", 32'(wb_error), 32'd0);
      $display("hand seq: dest=%0d alu=%h pend=%h err=%0b", rf_dest, rf_alu_data, pending, wb_error);
      n_vec++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
